// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and vertical-region encodings for the
// VGA sync generator and the counter blocks that feed it.
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int FB_SHIFT = 2;

    typedef enum logic [1:0] {
        V_ACT   = 2'd0,
        V_FRONT = 2'd1,
        V_SYNCS = 2'd2,
        V_BACK  = 2'd3
    } v_region_e;

    // Region that legally follows r when V_Count advances normally.
    function automatic v_region_e v_region_succ(input v_region_e r);
        case (r)
            V_ACT:   return V_FRONT;
            V_FRONT: return V_SYNCS;
            V_SYNCS: return V_BACK;
            default: return V_ACT;
        endcase
    endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational framebuffer address: (V>>SHIFT)*160 + (H>>SHIFT), built from
// shifts and adds so no multiplier is inferred.
module fb_addr_calc #(
    parameter int SHIFT = vga_timing_pkg::FB_SHIFT
) (
    input  logic [15:0] h,
    input  logic [15:0] v,
    output logic [14:0] addr
);

    logic [14:0] row;
    logic [14:0] col;

    assign row  = 15'(v >> SHIFT);
    assign col  = 15'(h >> SHIFT);
    // 160 = 128 + 32
    assign addr = (row << 7) + (row << 5) + col;

endmodule

// File: rtl/vga_sync_gen.sv
// Two-stage VGA timing decode: stage 1 decodes the counters and issues the
// framebuffer read, stage 2 aligns syncs and strobes with the returned pixel.
module vga_sync_gen #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int FB_SHIFT = vga_timing_pkg::FB_SHIFT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixel_en,
    input  logic [15:0] H_Count,
    input  logic [15:0] V_Count,
    input  logic [7:0]  rgb_in,
    output logic [14:0] fb_addr,
    output logic [7:0]  rgb_out,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start,
    output logic        timing_err
);

    localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
    localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_FIRST = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] VS_FIRST = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic h_bad, v_bad, range_err;
    logic act, hs, vs, ls, fs;
    logic [14:0] addr_calc;

    assign h_bad     = H_Count > H_LAST;
    assign v_bad     = V_Count > V_LAST;
    assign range_err = h_bad || v_bad;

    // Out-of-range coordinates are fully blanked rather than partially decoded.
    assign act = !range_err && (H_Count < H_VIS) && (V_Count < V_VIS);
    assign hs  = !range_err && (H_Count >= HS_FIRST) && (H_Count <= HS_LAST);
    assign vs  = !range_err && (V_Count >= VS_FIRST) && (V_Count <= VS_LAST);
    assign ls  = !range_err && (H_Count == 16'd0) && (V_Count < V_VIS);
    assign fs  = (H_Count == 16'd0) && (V_Count == 16'd0);

    fb_addr_calc #(.SHIFT(FB_SHIFT)) u_fb_addr_calc (
        .h    (H_Count),
        .v    (V_Count),
        .addr (addr_calc)
    );

    vga_timing_pkg::v_region_e v_state, v_next, v_region;
    logic jump_err;

    always_comb begin
        if (V_Count < V_VIS)          v_region = vga_timing_pkg::V_ACT;
        else if (V_Count < VS_FIRST)  v_region = vga_timing_pkg::V_FRONT;
        else if (V_Count <= VS_LAST)  v_region = vga_timing_pkg::V_SYNCS;
        else                          v_region = vga_timing_pkg::V_BACK;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        v_next   = v_state;
        jump_err = 1'b0;
        if (!v_bad) begin
            v_next   = v_region;
            jump_err = (v_region != v_state) &&
                       (v_region != vga_timing_pkg::v_region_succ(v_state));
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples
    // the pre-edge values, regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset)         v_state <= vga_timing_pkg::V_BACK;
        else if (pixel_en) v_state <= v_next;
    end

    logic act_q, hs_q, vs_q, ls_q, fs_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q   <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fb_addr <= '0;
        end else if (pixel_en) begin
            act_q <= act;
            hs_q  <= hs;
            vs_q  <= vs;
            ls_q  <= ls;
            fs_q  <= fs;
            // Address holds through blanking so the memory sees no spurious reads.
            if (act) fb_addr <= addr_calc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_out     <= 8'h00;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pixel_en) begin
            rgb_out     <= act_q ? rgb_in : 8'h00;
            hsync       <= ~hs_q;
            vsync       <= ~vs_q;
            video_on    <= act_q;
            line_start  <= ls_q;
            frame_start <= fs_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                                   timing_err <= 1'b0;
        else if (pixel_en && (range_err || jump_err)) timing_err <= 1'b1;
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a reference model pushes expected stage-2
// outputs per strobe and pops them when the pipeline delivers them.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       video_on;
        logic       line_start;
        logic       frame_start;
        logic [7:0] rgb;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_en = 1'b0;
    logic [15:0] H_Count = '0;
    logic [15:0] V_Count = '0;
    logic [7:0]  rgb_in = '0;
    logic [14:0] fb_addr;
    logic [7:0]  rgb_out;
    logic        hsync, vsync, video_on, line_start, frame_start, timing_err;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];
    exp_t last_exp;
    vga_timing_pkg::v_region_e m_state;
    logic        m_err;
    logic [14:0] m_addr;
    logic [7:0]  pend_d;

    vga_sync_gen dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_en    (pixel_en),
        .H_Count     (H_Count),
        .V_Count     (V_Count),
        .rgb_in      (rgb_in),
        .fb_addr     (fb_addr),
        .rgb_out     (rgb_out),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .line_start  (line_start),
        .frame_start (frame_start),
        .timing_err  (timing_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check({tag, ".hsync"},       32'(hsync),       32'(e.hsync));
        check({tag, ".vsync"},       32'(vsync),       32'(e.vsync));
        check({tag, ".video_on"},    32'(video_on),    32'(e.video_on));
        check({tag, ".line_start"},  32'(line_start),  32'(e.line_start));
        check({tag, ".frame_start"}, 32'(frame_start), 32'(e.frame_start));
        check({tag, ".rgb_out"},     32'(rgb_out),     32'(e.rgb));
    endtask

    function automatic vga_timing_pkg::v_region_e region_of(input int v);
        if (v < 480)      return vga_timing_pkg::V_ACT;
        else if (v < 490) return vga_timing_pkg::V_FRONT;
        else if (v < 492) return vga_timing_pkg::V_SYNCS;
        else              return vga_timing_pkg::V_BACK;
    endfunction

    function automatic vga_timing_pkg::v_region_e succ_of(input vga_timing_pkg::v_region_e r);
        case (r)
            vga_timing_pkg::V_ACT:   return vga_timing_pkg::V_FRONT;
            vga_timing_pkg::V_FRONT: return vga_timing_pkg::V_SYNCS;
            vga_timing_pkg::V_SYNCS: return vga_timing_pkg::V_BACK;
            default:                 return vga_timing_pkg::V_ACT;
        endcase
    endfunction

    function automatic exp_t blank_exp();
        exp_t e;
        e = '0;
        e.hsync = 1'b1;
        e.vsync = 1'b1;
        return e;
    endfunction

    // One pixel strobe at (h,v); d is the framebuffer word for that pixel,
    // returned on rgb_in at the following strobe.
    task automatic strobe(input int h, input int v, input logic [7:0] d);
        exp_t e;
        bit inr, act;
        vga_timing_pkg::v_region_e r;
        inr = (h < 800) && (v < 525);
        act = inr && (h < 640) && (v < 480);
        e.hsync       = !(inr && h >= 656 && h <= 751);
        e.vsync       = !(inr && v >= 490 && v <= 491);
        e.video_on    = act;
        e.line_start  = inr && h == 0 && v < 480;
        e.frame_start = (h == 0) && (v == 0);
        e.rgb         = act ? d : 8'h00;
        sb.push_back(e);
        if (act) m_addr = 15'((v / 4) * 160 + (h / 4));
        if (!inr) m_err = 1'b1;
        else begin
            r = region_of(v);
            if (r != m_state && r != succ_of(m_state)) m_err = 1'b1;
            m_state = r;
        end
        H_Count  = 16'(h);
        V_Count  = 16'(v);
        rgb_in   = pend_d;
        pend_d   = d;
        pixel_en = 1'b1;
        @(posedge clk);
        #1;
        pixel_en = 1'b0;
        last_exp = sb.pop_front();
        check_outputs("pix", last_exp);
        check("fb_addr",    32'(fb_addr),     32'(m_addr));
        check("timing_err", 32'(timing_err),  32'(m_err));
        check("v_state",    32'(dut.v_state), 32'(m_state));
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int cycles);
        reset    = 1'b1;
        pixel_en = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst.fb_addr",    32'(fb_addr),     32'd0);
        check("rst.timing_err", 32'(timing_err),  32'd0);
        check("rst.v_state",    32'(dut.v_state), 32'(vga_timing_pkg::V_BACK));
        check_outputs("rst", blank_exp());
        reset   = 1'b0;
        m_state = vga_timing_pkg::V_BACK;
        m_err   = 1'b0;
        m_addr  = '0;
        pend_d  = '0;
        sb.delete();
        sb.push_back(blank_exp());
    endtask

    int hs_low, vid_cnt, first_low, fs_cnt;
    int hlist[7] = '{0, 655, 656, 700, 751, 752, 799};

    initial begin
        pend_d = '0;
        apply_reset(3);

        // Address spot checks and one pixel through the data path.
        strobe(4, 4, 8'h11);
        check("addr_4_4", 32'(fb_addr), 32'd161);
        strobe(639, 479, 8'h22);
        check("addr_639_479", 32'(fb_addr), 32'd19199);
        strobe(0, 0, 8'hE3);
        check("addr_0_0", 32'(fb_addr), 32'd0);
        strobe(1, 0, 8'h33);
        check("rgb_e3", 32'(rgb_out), 32'hE3);
        strobe(700, 0, 8'hFF);
        strobe(701, 0, 8'hFF);
        check("rgb_blank", 32'(rgb_out), 32'h00);

        // One complete line: sync width, sync position and visible count.
        hs_low = 0; vid_cnt = 0; first_low = -1;
        for (int h = 0; h < 800; h++) begin
            strobe(h, 100, 8'(h ^ 100));
            if (h >= 1) begin
                if (!hsync) begin
                    hs_low++;
                    if (first_low < 0) first_low = h - 1;
                end
                if (video_on) vid_cnt++;
            end
        end
        check("line.hs_low_count", 32'(hs_low), 32'd96);
        check("line.hs_first_h",   32'(first_low), 32'd656);
        check("line.video_count",  32'(vid_cnt), 32'd640);

        // Stalled pixel_en mid-line: outputs frozen, pulse neither repeated nor dropped.
        strobe(0, 100, 8'h44);
        strobe(1, 100, 8'h45);
        check("frz.line_start_pulse", 32'(line_start), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check_outputs("frz", last_exp);
            check("frz.fb_addr", 32'(fb_addr), 32'(m_addr));
        end
        strobe(2, 100, 8'h46);
        check("frz.line_start_end", 32'(line_start), 32'd0);

        // Walk the bottom of the frame through every vertical region.
        for (int v = 478; v < 524; v++)
            foreach (hlist[i]) strobe(hlist[i], v, 8'(v));

        // Frame wrap 799/524 -> 0/0.
        fs_cnt = 0;
        for (int h = 795; h < 800; h++) begin
            strobe(h, 524, 8'h5A);
            if (frame_start) fs_cnt++;
        end
        check("wrap.state_back", 32'(dut.v_state), 32'(vga_timing_pkg::V_BACK));
        for (int h = 0; h < 4; h++) begin
            strobe(h, 0, 8'(8'hA0 + h));
            if (frame_start) fs_cnt++;
        end
        check("wrap.frame_start_count", 32'(fs_cnt), 32'd1);
        check("wrap.state_act", 32'(dut.v_state), 32'(vga_timing_pkg::V_ACT));
        check("wrap.no_err", 32'(timing_err), 32'd0);

        // Out-of-range H: blanked and sticky error.
        strobe(900, 10, 8'h77);
        check("herr.timing_err", 32'(timing_err), 32'd1);
        strobe(5, 10, 8'h78);
        check("herr.blanked", 32'(video_on), 32'd0);
        strobe(6, 10, 8'h79);
        check("herr.sticky", 32'(timing_err), 32'd1);

        // Reset mid-line at (320,240) with pixel_en low.
        for (int h = 316; h <= 320; h++) strobe(h, 240, 8'(h));
        apply_reset(1);
        for (int h = 321; h <= 330; h++) begin
            strobe(h, 240, 8'(h));
            if (h == 322) check("rst.resume_video", 32'(video_on), 32'd1);
        end

        // Vertical jump from active straight into the sync region.
        strobe(10, 100, 8'h12);
        check("vjump.pre_err", 32'(timing_err), 32'd0);
        strobe(10, 495, 8'h13);
        check("vjump.state", 32'(dut.v_state), 32'(vga_timing_pkg::V_BACK));
        strobe(11, 100, 8'h14);
        check("vjump2.pre_state", 32'(dut.v_state), 32'(vga_timing_pkg::V_ACT));
        apply_reset(1);
        strobe(10, 100, 8'h15);
        strobe(10, 491, 8'h16);
        check("vjump.syncs_state", 32'(dut.v_state), 32'(vga_timing_pkg::V_SYNCS));
        check("vjump.timing_err", 32'(timing_err), 32'd1);
        strobe(11, 491, 8'h17);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
